// File: rtl/jtdd_gfx_arb_pkg.sv
// Shared types for the graphics ROM arbiter: requester ids, FSM states and
// the SDRAM word address width.
package jtdd_gfx_pkg;

  localparam int SDRAM_AW = 22;

  typedef enum logic [1:0] {
    SLOT_CHAR = 2'd0,
    SLOT_SCR  = 2'd1,
    SLOT_OBJ  = 2'd2
  } slot_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Round-robin successor in the order char -> scr -> obj -> char.
  function automatic slot_e next_slot(input slot_e s);
    case (s)
      SLOT_CHAR: next_slot = SLOT_SCR;
      SLOT_SCR:  next_slot = SLOT_OBJ;
      default:   next_slot = SLOT_CHAR;
    endcase
  endfunction

endpackage

// File: rtl/jtdd_gfx_arb_if.sv
// SDRAM read port between the graphics arbiter (master) and the SDRAM
// controller (slave).
interface jtdd_gfx_arb_if;
  import jtdd_gfx_pkg::*;

  logic                sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_ack;
  logic                data_rdy;
  logic [15:0]         sdram_din;

  modport master (
    output sdram_req,
    output sdram_addr,
    input  sdram_ack,
    input  data_rdy,
    input  sdram_din
  );

  modport slave (
    input  sdram_req,
    input  sdram_addr,
    output sdram_ack,
    output data_rdy,
    output sdram_din
  );

endinterface

// File: rtl/jtdd_gfx_slot.sv
// One-word tag/data cache entry for a single graphics ROM requester.
module jtdd_gfx_slot #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [AW-1:0] wr_tag,
  input  logic [15:0]   wr_data,
  output logic          hit,
  output logic [15:0]   data
);

  logic          valid_q, valid_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [15:0]   data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr) begin
      valid_d = 1'b1;
      tag_d   = wr_tag;
      data_d  = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  // Hit is combinational so ok drops in the same cycle the address moves.
  assign hit  = valid_q && (tag_q == addr);
  assign data = data_q;

endmodule

// File: rtl/jtdd_gfx_arb.sv
// Shares one SDRAM read port between the char, scroll and object ROM
// requesters using per-requester one-word caches and round-robin misses.
module jtdd_gfx_arb
  import jtdd_gfx_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] CHAR_OFFSET = 22'h00000,
  parameter logic [SDRAM_AW-1:0] SCR_OFFSET  = 22'h10000,
  parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h30000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [14:0]           char_addr,
  output logic [7:0]            char_data,
  output logic                  char_ok,
  input  logic [16:0]           scr_addr,
  output logic [15:0]           scr_data,
  output logic                  scr_ok,
  input  logic [17:0]           obj_addr,
  output logic [15:0]           obj_data,
  output logic                  obj_ok,
  jtdd_gfx_arb_if.master        sdram
);

  state_e              state_q, state_d;
  slot_e               grant_q, grant_d;
  slot_e               rr_q, rr_d;
  logic [17:0]         tag_q, tag_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;

  logic        char_hit, scr_hit, obj_hit;
  logic [15:0] char_word;
  logic        wr_char, wr_scr, wr_obj;
  logic        any_pend;
  slot_e       pick;
  logic [17:0] pick_word;
  logic [SDRAM_AW-1:0] pick_offset;

  jtdd_gfx_slot #(.AW(14)) u_char (
    .clk(clk), .rstn(rstn), .addr(char_addr[14:1]), .wr(wr_char),
    .wr_tag(tag_q[13:0]), .wr_data(sdram.sdram_din),
    .hit(char_hit), .data(char_word)
  );

  jtdd_gfx_slot #(.AW(17)) u_scr (
    .clk(clk), .rstn(rstn), .addr(scr_addr), .wr(wr_scr),
    .wr_tag(tag_q[16:0]), .wr_data(sdram.sdram_din),
    .hit(scr_hit), .data(scr_data)
  );

  jtdd_gfx_slot #(.AW(18)) u_obj (
    .clk(clk), .rstn(rstn), .addr(obj_addr), .wr(wr_obj),
    .wr_tag(tag_q), .wr_data(sdram.sdram_din),
    .hit(obj_hit), .data(obj_data)
  );

  function automatic logic pending(input slot_e s, input logic ch,
                                   input logic sh, input logic oh);
    case (s)
      SLOT_CHAR: pending = !ch;
      SLOT_SCR:  pending = !sh;
      default:   pending = !oh;
    endcase
  endfunction

  // Search starts at rr_q, which holds the slot after the last one served.
  always_comb begin
    slot_e s1, s2;
    s1       = next_slot(rr_q);
    s2       = next_slot(s1);
    pick     = rr_q;
    any_pend = 1'b1;
    if (pending(rr_q, char_hit, scr_hit, obj_hit)) pick = rr_q;
    else if (pending(s1, char_hit, scr_hit, obj_hit)) pick = s1;
    else if (pending(s2, char_hit, scr_hit, obj_hit)) pick = s2;
    else any_pend = 1'b0;
  end

  always_comb begin
    pick_word   = '0;
    pick_offset = '0;
    case (pick)
      SLOT_CHAR: begin
        pick_word   = {4'd0, char_addr[14:1]};
        pick_offset = CHAR_OFFSET;
      end
      SLOT_SCR: begin
        pick_word   = {1'b0, scr_addr};
        pick_offset = SCR_OFFSET;
      end
      default: begin
        pick_word   = obj_addr;
        pick_offset = OBJ_OFFSET;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          grant_d = pick;
          tag_d   = pick_word;
          addr_d  = pick_offset + {4'd0, pick_word};
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram.sdram_ack) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sdram.data_rdy) begin
          rr_d    = next_slot(grant_q);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      grant_q <= SLOT_CHAR;
      rr_q    <= SLOT_CHAR;
      tag_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
    end
  end

  // The fetched word lands under the in-flight tag even if the address moved.
  assign wr_char = (state_q == ST_WAIT) && sdram.data_rdy && (grant_q == SLOT_CHAR);
  assign wr_scr  = (state_q == ST_WAIT) && sdram.data_rdy && (grant_q == SLOT_SCR);
  assign wr_obj  = (state_q == ST_WAIT) && sdram.data_rdy && (grant_q == SLOT_OBJ);

  assign sdram.sdram_req  = (state_q == ST_REQ);
  assign sdram.sdram_addr = addr_q;

  assign char_ok   = char_hit;
  assign scr_ok    = scr_hit;
  assign obj_ok    = obj_hit;
  assign char_data = char_addr[0] ? char_word[15:8] : char_word[7:0];

endmodule

// File: tb/tb_jtdd_gfx_arb.sv
// Directed self-checking bench for jtdd_gfx_arb: a linear sequence of steps
// acting as SDRAM controller, with hand-computed expected values.
module tb_jtdd_gfx_arb;

  logic        clk;
  logic        rstn;
  logic [14:0] char_addr;
  logic [7:0]  char_data;
  logic        char_ok;
  logic [16:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ok;
  logic [17:0] obj_addr;
  logic [15:0] obj_data;
  logic        obj_ok;

  int checks = 0;
  int errors = 0;

  jtdd_gfx_arb_if sd ();

  jtdd_gfx_arb dut (
    .clk(clk), .rstn(rstn),
    .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram(sd.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [14:0] ca, input logic [16:0] sa,
                               input logic [17:0] oa);
    char_addr = ca;
    scr_addr  = sa;
    obj_addr  = oa;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !sd.sdram_req; i++) step();
    checkOutput("req_seen", {31'd0, sd.sdram_req}, 32'd1);
  endtask

  task automatic serve(input string tag, input logic [21:0] exp_addr,
                       input logic [15:0] din);
    wait_req();
    checkOutput({tag, "_addr"}, {10'd0, sd.sdram_addr}, {10'd0, exp_addr});
    sd.sdram_ack = 1'b1;
    step();
    sd.sdram_ack = 1'b0;
    checkOutput({tag, "_req_drop"}, {31'd0, sd.sdram_req}, 32'd0);
    sd.data_rdy  = 1'b1;
    sd.sdram_din = din;
    step();
    sd.data_rdy  = 1'b0;
  endtask

  initial begin
    rstn         = 1'b0;
    sd.sdram_ack = 1'b0;
    sd.data_rdy  = 1'b0;
    sd.sdram_din = 16'h0000;
    applyStimulus(15'h0000, 17'h00000, 18'h00000);
    repeat (4) step();

    checkOutput("rst_char_ok", {31'd0, char_ok}, 32'd0);
    checkOutput("rst_scr_ok", {31'd0, scr_ok}, 32'd0);
    checkOutput("rst_obj_ok", {31'd0, obj_ok}, 32'd0);
    checkOutput("rst_char_data", {24'd0, char_data}, 32'd0);
    checkOutput("rst_scr_data", {16'd0, scr_data}, 32'd0);
    checkOutput("rst_obj_data", {16'd0, obj_data}, 32'd0);
    checkOutput("rst_req", {31'd0, sd.sdram_req}, 32'd0);
    checkOutput("rst_addr", {10'd0, sd.sdram_addr}, 32'd0);

    $display("[TB] cold start: char, scr, obj in order");
    rstn = 1'b1;
    serve("t1_char", 22'h00000, 16'h1234);
    checkOutput("t1_char_ok", {31'd0, char_ok}, 32'd1);
    checkOutput("t1_char_data", {24'd0, char_data}, 32'h34);
    serve("t1_scr", 22'h10000, 16'hBEEF);
    checkOutput("t1_scr_ok", {31'd0, scr_ok}, 32'd1);
    checkOutput("t1_scr_data", {16'd0, scr_data}, 32'hBEEF);
    serve("t1_obj", 22'h30000, 16'hCAFE);
    checkOutput("t1_obj_ok", {31'd0, obj_ok}, 32'd1);
    checkOutput("t1_obj_data", {16'd0, obj_data}, 32'hCAFE);

    $display("[TB] byte select within a cached char word");
    applyStimulus(15'h0002, 17'h00000, 18'h00000);
    serve("t2_char", 22'h00001, 16'hA55A);
    checkOutput("t2_char_ok_lo", {31'd0, char_ok}, 32'd1);
    checkOutput("t2_char_lo", {24'd0, char_data}, 32'h5A);
    applyStimulus(15'h0003, 17'h00000, 18'h00000);
    #1;
    checkOutput("t2_char_ok_hi", {31'd0, char_ok}, 32'd1);
    checkOutput("t2_char_hi", {24'd0, char_data}, 32'hA5);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("t2_no_req", {31'd0, sd.sdram_req}, 32'd0);
    end

    $display("[TB] round-robin after a scr grant");
    applyStimulus(15'h0003, 17'h00001, 18'h00000);
    serve("t3_pre_scr", 22'h10001, 16'h0D01);
    applyStimulus(15'h0004, 17'h00002, 18'h00001);
    serve("t3_obj", 22'h30001, 16'h0B01);
    serve("t3_char", 22'h00002, 16'h0C02);
    serve("t3_scr", 22'h10002, 16'h0D02);
    checkOutput("t3_obj_data", {16'd0, obj_data}, 32'h0B01);
    checkOutput("t3_char_data", {24'd0, char_data}, 32'h02);
    checkOutput("t3_scr_data", {16'd0, scr_data}, 32'h0D02);
    checkOutput("t3_all_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'd7);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("t3_no_extra_req", {31'd0, sd.sdram_req}, 32'd0);
    end

    $display("[TB] scr address moves while its read is in flight");
    applyStimulus(15'h0004, 17'h00100, 18'h00001);
    wait_req();
    checkOutput("t4_addr_old", {10'd0, sd.sdram_addr}, 32'h10100);
    sd.sdram_ack = 1'b1;
    step();
    sd.sdram_ack = 1'b0;
    applyStimulus(15'h0004, 17'h00200, 18'h00001);
    sd.data_rdy  = 1'b1;
    sd.sdram_din = 16'h1111;
    step();
    sd.data_rdy  = 1'b0;
    checkOutput("t4_scr_ok_stale", {31'd0, scr_ok}, 32'd0);
    serve("t4_scr_new", 22'h10200, 16'h2222);
    checkOutput("t4_scr_ok", {31'd0, scr_ok}, 32'd1);
    checkOutput("t4_scr_data", {16'd0, scr_data}, 32'h2222);

    $display("[TB] reset during WAIT");
    applyStimulus(15'h0004, 17'h00200, 18'h00055);
    wait_req();
    checkOutput("t5_addr", {10'd0, sd.sdram_addr}, 32'h30055);
    sd.sdram_ack = 1'b1;
    step();
    sd.sdram_ack = 1'b0;
    rstn = 1'b0;
    step();
    checkOutput("t5_req_rst", {31'd0, sd.sdram_req}, 32'd0);
    sd.data_rdy  = 1'b1;
    sd.sdram_din = 16'h3333;
    step();
    sd.data_rdy  = 1'b0;
    checkOutput("t5_oks", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
    checkOutput("t5_obj_data", {16'd0, obj_data}, 32'd0);
    checkOutput("t5_req", {31'd0, sd.sdram_req}, 32'd0);
    rstn = 1'b1;
    serve("t5_char", 22'h00002, 16'h4444);
    checkOutput("t5_char_data", {24'd0, char_data}, 32'h44);
    serve("t5_scr", 22'h10200, 16'h5555);
    serve("t5_obj", 22'h30055, 16'h6666);
    checkOutput("t5_obj_ok", {31'd0, obj_ok}, 32'd1);
    checkOutput("t5_obj_data2", {16'd0, obj_data}, 32'h6666);

    $display("[TB] slow ack holds request stable");
    applyStimulus(15'h0006, 17'h00200, 18'h00055);
    wait_req();
    checkOutput("t6_addr", {10'd0, sd.sdram_addr}, 32'h00003);
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("t6_req_hold", {31'd0, sd.sdram_req}, 32'd1);
      checkOutput("t6_addr_hold", {10'd0, sd.sdram_addr}, 32'h00003);
      checkOutput("t6_oks_hold", {29'd0, char_ok, scr_ok, obj_ok}, 32'd3);
    end
    sd.sdram_ack = 1'b1;
    step();
    sd.sdram_ack = 1'b0;
    sd.data_rdy  = 1'b1;
    sd.sdram_din = 16'h7788;
    step();
    sd.data_rdy  = 1'b0;
    checkOutput("t6_char_ok", {31'd0, char_ok}, 32'd1);
    checkOutput("t6_char_data", {24'd0, char_data}, 32'h88);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
